// File: rtl/btn_num_entry.sv
// btn_num_entry: two debounced pushbuttons stepping the nibbles of an 8-bit value, with hold-to-auto-repeat.
module btn_num_entry #(
  parameter int DB_MAX   = 1000000,
  parameter int HOLD_MAX = 50000000,
  parameter int RPT_MAX  = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn,
  output logic [7:0] num,
  output logic [1:0] btn_db,
  output logic [1:0] press,
  output logic       upd
);
  typedef enum logic [1:0] {IDLE, HELD, RPT} st_t;
  logic [1:0] s1, s2, press_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [25:0] dc, hc, hc_n;
    logic db, flip, rise, hexp, rexp, pn;
    st_t st, st_n;
    assign flip = (s2[i] != db) && (dc + 26'd1 == 26'(DB_MAX));
    assign rise = flip & ~db;
    assign hexp = hc + 26'd1 == 26'(HOLD_MAX);
    assign rexp = hc + 26'd1 == 26'(RPT_MAX);
    assign btn_db[i] = db;
    assign press_n[i] = pn;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        dc <= '0;
        db <= 1'b0;
      end else begin
        dc <= (s2[i] == db || flip) ? '0 : dc + 26'd1;
        db <= db ^ flip;
      end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st <= IDLE;
        hc <= '0;
      end else begin
        st <= st_n;
        hc <= hc_n;
      end
    // A rise can only occur while db is low, so it takes priority over the release path
    always_comb begin
      st_n = rise ? HELD :
             (st != IDLE && !db) ? IDLE :
             (st == HELD && hexp) ? RPT : st;
    end
    always_comb begin
      pn   = rise | (db & ((st == HELD & hexp) | (st == RPT & rexp)));
      hc_n = (st == IDLE || pn || !db) ? '0 : hc + 26'd1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      num   <= '0;
      press <= '0;
      upd   <= 1'b0;
    end else begin
      num   <= {num[7:4] + 4'(press_n[1]), num[3:0] + 4'(press_n[0])};
      press <= press_n;
      upd   <= |press_n;
    end
endmodule

// File: tb/tb_btn_num_entry.sv
// tb_btn_num_entry: directed and randomized checks of btn_num_entry against a timing-based reference model.
module tb_btn_num_entry;
  localparam int DB = 4, HOLD = 20, RPT = 8;
  logic       clk = 0, rst = 1;
  logic [1:0] btn = '0;
  logic [7:0] num;
  logic [1:0] btn_db, press;
  logic       upd;
  int cmps = 0, errs = 0;

  btn_num_entry #(.DB_MAX(DB), .HOLD_MAX(HOLD), .RPT_MAX(RPT)) dut (
    .clk(clk), .rst(rst), .btn(btn), .num(num), .btn_db(btn_db), .press(press), .upd(upd)
  );

  always #5 clk = ~clk;

  // Model: sync delay line, run-length debounce, and presses scheduled by time since the debounced rise
  logic [1:0] s1m, s2m, dbm, pm;
  logic [7:0] nm;
  logic       um;
  int dcm [2];
  int rt [2];
  int k;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1m = '0; s2m = '0; dbm = '0; pm = '0; nm = '0; um = 0; k = 0;
      for (int i = 0; i < 2; i++) begin dcm[i] = 0; rt[i] = -1; end
    end else begin
      k++;
      for (int i = 0; i < 2; i++) begin
        logic dprev, r;
        dprev = dbm[i];
        r = 0;
        if (s2m[i] != dbm[i]) begin
          dcm[i]++;
          if (dcm[i] == DB) begin dbm[i] = ~dbm[i]; dcm[i] = 0; r = !dprev; end
        end else dcm[i] = 0;
        pm[i] = r || (dprev && rt[i] >= 0 && k - rt[i] >= HOLD && (k - rt[i] - HOLD) % RPT == 0);
        if (r) rt[i] = k;
      end
      s2m = s1m;
      s1m = btn;
      nm = {nm[7:4] + 4'(pm[1]), nm[3:0] + 4'(pm[0])};
      um = |pm;
    end
  end

  always @(negedge clk) begin
    cmps++;
    if ({num, btn_db, press, upd} !== {nm, dbm, pm, um}) begin
      errs++;
      $display("FAIL model t=%0t: num=%h db=%b press=%b upd=%b, want num=%h db=%b press=%b upd=%b",
               $time, num, btn_db, press, upd, nm, dbm, pm, um);
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    cmps++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    #1 rst = 1; btn = '0;
    step(2);
    rst = 0;
  endtask

  initial begin
    do_reset();
    chk("reset_num", num, 8'h00);
    chk("reset_db", {6'b0, btn_db}, 8'h00);
    // Clean step on btn[0]: debounced level and first increment land 6 edges later
    btn = 2'b01;
    step(5);
    chk("step_db_early", {6'b0, btn_db}, 8'h00);
    step(1);
    chk("step_db", {6'b0, btn_db}, 8'h01);
    chk("step_press", {5'b0, press, upd}, 8'h03);
    chk("step_num", num, 8'h01);
    step(1);
    chk("step_press_off", {5'b0, press, upd}, 8'h00);
    // Bounce on btn[1] yields one increment
    do_reset();
    for (int j = 0; j < 4; j++) begin btn = (j % 2 == 0) ? 2'b10 : 2'b00; step(2); end
    chk("bounce_quiet", num, 8'h00);
    btn = 2'b10;
    step(10);
    chk("bounce_num", num, 8'h10);
    btn = 2'b00;
    step(10);
    // Auto-repeat: six increments, released before the seventh is due
    do_reset();
    btn = 2'b01;
    step(59);
    btn = 2'b00;
    step(20);
    chk("repeat_num", num, 8'h06);
    // Low nibble wraps without carry
    do_reset();
    btn = 2'b10; step(10); btn = 2'b00; step(10);
    for (int j = 0; j < 15; j++) begin btn = 2'b01; step(10); btn = 2'b00; step(10); end
    chk("wrap_pre", num, 8'h1F);
    btn = 2'b01; step(10); btn = 2'b00; step(10);
    chk("wrap_num", num, 8'h10);
    // Simultaneous step on both buttons
    do_reset();
    btn = 2'b11;
    step(6);
    chk("both_num", num, 8'h11);
    chk("both_press", {5'b0, press, upd}, 8'h07);
    step(1);
    chk("both_off", {5'b0, press, upd}, 8'h00);
    btn = 2'b00; step(10);
    // Asynchronous reset while repeating, then a fresh increment
    do_reset();
    btn = 2'b01;
    step(35);
    #1 rst = 1;
    #1 chk("arst_num", num, 8'h00);
    chk("arst_out", {3'b0, btn_db, press, upd}, 8'h00);
    step(2);
    rst = 0;
    step(5);
    chk("arst_wait", num, 8'h00);
    step(1);
    chk("arst_again", num, 8'h01);
    btn = 2'b00; step(10);
    // Randomized button activity with occasional async resets
    for (int j = 0; j < 200; j++) begin
      if ($urandom_range(0, 29) == 0) begin
        #($urandom_range(0, 4)) rst = 1;
        #7 rst = 0;
      end
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(2, 8)) begin btn = 2'($urandom); step($urandom_range(1, 3)); end
      btn = 2'($urandom);
      step($urandom_range(1, 60));
    end
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/btn_num_entry.md
BTN_NUM_ENTRY -- requirements
Module: btn_num_entry

Interface
REQ-001 Parameter DB_MAX, default 1000000, is the number of consecutive clocks a synchronized button must differ from its debounced state before that state flips (10 ms at 100 MHz).
REQ-002 Parameter HOLD_MAX, default 50000000, is the number of clocks a debounced press is held before auto-repeat starts.
REQ-003 Parameter RPT_MAX, default 10000000, is the number of clocks between auto-repeat increments.
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 btn  input  2  raw, bouncy, asynchronous pushbuttons, active-high.
REQ-007 num  output  8  entered value; num[3:0] is stepped by btn[0], num[7:4] by btn[1]; feeds the 8-bit shift register parallel input and the display.
REQ-008 btn_db  output  2  debounced button levels.
REQ-009 press  output  2  per button, one-cycle pulse per increment event (initial press or auto-repeat).
REQ-010 upd  output  1  one-cycle pulse in any cycle where num changed.

Function
REQ-011 Each btn bit SHALL pass through a 2-flop synchronizer before any other logic; no other logic SHALL use raw btn.
REQ-012 Per button, a debounce counter SHALL increment on each clock where synchronized input differs from btn_db, and SHALL clear to 0 on any clock where they are equal.
REQ-013 When the debounce counter would reach DB_MAX, btn_db SHALL toggle on that edge and the counter SHALL clear; first btn_db change is therefore 2 + DB_MAX edges after a clean input step.
REQ-014 Counters SHALL be 26 bits; parameter values SHALL be in 1 .. 2^26-1, and counters SHALL never wrap.
REQ-015 Per button, an FSM SHALL have states IDLE, HELD and REPEAT; reset state is IDLE.
REQ-016 IDLE -> HELD on the edge where btn_db rises; on that same edge press SHALL be set, the nibble incremented, and the hold counter cleared.
REQ-017 In HELD, the hold counter increments each clock; when it would reach HOLD_MAX: -> REPEAT, press set, nibble incremented, counter cleared.
REQ-018 In REPEAT, the counter increments each clock; when it would reach RPT_MAX: press set, nibble incremented, counter cleared, remain in REPEAT.
REQ-019 From HELD or REPEAT, btn_db low SHALL force -> IDLE with counter cleared and no increment on that edge, overriding a simultaneous hold or repeat expiry.
REQ-020 Nibble increment SHALL be modulo 16 (F -> 0), with no carry between nibbles.
REQ-021 press SHALL be high for exactly one cycle per increment; consecutive increments of one button SHALL be separated by at least RPT_MAX cycles.
REQ-022 Both buttons incrementing on the same edge SHALL update both nibbles on that edge and produce a single one-cycle upd pulse.
REQ-023 upd SHALL equal the OR of the press bits, registered on the same edge as the num update.
REQ-024 All outputs SHALL be driven from registers.

Reset
REQ-025 While rst is high: num=8'h00, btn_db=2'b00, press=2'b00, upd=0, synchronizers and all counters 0, both FSMs IDLE.
REQ-026 rst asserted mid-operation (any state, any count) SHALL clear everything immediately without a clock; after release, a button still held SHALL be debounced afresh and produce a new initial increment.

Verification (DB_MAX=4, HOLD_MAX=20, RPT_MAX=8)
REQ-027 Clean btn[0] step 0->1 after reset -> btn_db[0] rises 6 edges later; press[0] and upd pulse 1 cycle; num=8'h01.
REQ-028 btn[1] bounce 1,0,1,0 toggling every 2 clocks, then stable 1 -> exactly one increment; num=8'h10; no press during bounce.
REQ-029 btn[0] held 60 cycles after btn_db rise -> increments at +0, +20, +28, +36, +44, +52; num[3:0]=6; press pulses each one cycle.
REQ-030 num[3:0]=4'hF, btn[0] pressed -> num[3:0]=0, num[7:4] unchanged.
REQ-031 Both buttons stepped on the same clock -> num 8'h00->8'h11 on one edge; single upd pulse; press=2'b11 for one cycle.
REQ-032 rst pulsed during REPEAT with btn[0] still high -> outputs 0 asynchronously; after release, next increment is 6 edges later, with num=8'h01.
